// File: rtl/rv_insn_if.sv
// Field-bundle input and byte-stream output of the RISC-V instruction encoder.
// master drives bundles and the sink ready; slave is the encoder.
interface rv_insn_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [19:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, func3, func7, imm, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, func3, func7, imm, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/rv_insn_encoder.sv
// Packs R/I/U instruction fields into a 32-bit word and streams it as four bytes.
// A new bundle can be accepted on the last byte of the current word for gapless output.
module rv_insn_encoder #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rv_insn_if.slave         bus,
  output logic [31:0]      last_word,
  output logic             err,
  output logic [CNT_W-1:0] insn_count
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      last_word_q, last_word_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] enc_word;
  logic        ready;
  logic        accept;
  logic        legal;
  logic        xfer;
  logic [1:0]  byte_sel;

  always_comb begin
    enc_word = '0;
    case (bus.fmt)
      2'd0:    enc_word = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
      2'd1:    enc_word = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
      2'd2:    enc_word = {bus.imm, bus.rd, bus.opcode};
      default: enc_word = '0;
    endcase
  end

  // out_ready reaches in_ready only on the last byte, so the next word can follow without a bubble
  assign ready  = (state_q == StIdle) || ((idx_q == 2'd3) && bus.out_ready);
  assign accept = bus.in_valid && ready;
  assign legal  = (bus.fmt != 2'd3);
  assign xfer   = (state_q == StSend) && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    last_word_d = last_word_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (legal) begin
            word_d      = enc_word;
            last_word_d = enc_word;
            idx_d       = 2'd0;
            state_d     = StSend;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (accept && legal) begin
              word_d      = enc_word;
              last_word_d = enc_word;
              idx_d       = 2'd0;
            end else begin
              err_d   = accept;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      word_q      <= '0;
      idx_q       <= 2'd0;
      last_word_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      last_word_q <= last_word_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign byte_sel      = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == StSend);
  assign bus.out_byte  = word_q[{byte_sel, 3'b000} +: 8];
  assign bus.out_last  = (state_q == StSend) && (idx_q == 2'd3);
  assign last_word     = last_word_q;
  assign err           = err_q;
  assign insn_count    = cnt_q;

endmodule

// File: doc/rv_insn_encoder.md
# rv_insn_encoder

Encodes RISC-V R/I/U-format instruction fields into a 32-bit instruction word and streams it out as four bytes over a valid/ready byte interface. It is the transmit-side counterpart of the packed-union instruction decode (`instruction_t` with `r`/`i`/`u` views). It sits between an instruction generator (test sequencer or assembler front end) and a byte-wide memory or link writer.

## Interface
- `MSB_FIRST`, default 0: byte order. 0 sends bits [7:0] first; 1 sends bits [31:24] first.
- `CNT_W`, default 16: width of the encoded-instruction counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept a bundle.
- `fmt`  in  2  format: 0=R, 1=I, 2=U, 3=illegal.
- `opcode`  in  7  opcode field.
- `rd`, `rs1`, `rs2`  in  5 each  register addresses.
- `func3`  in  3  funct3.
- `func7`  in  7  funct7.
- `imm`  in  20  immediate. I uses [11:0]; U uses [19:0].
- `out_valid`  out  1  byte valid.
- `out_ready`  in  1  sink accepts byte.
- `out_byte`  out  8  current byte.
- `out_last`  out  1  high on the 4th byte of a word.
- `last_word`  out  32  most recently encoded legal word.
- `err`  out  1  one-cycle pulse when an illegal `fmt` is accepted.
- `insn_count`  out  CNT_W  number of legal words fully sent; wraps modulo 2^CNT_W.

## Operation
Word encoding, MSB to LSB:
- R: {func7, rs2, rs1, func3, rd, opcode}.
- I: {imm[11:0], rs1, func3, rd, opcode}.
- U: {imm[19:0], rd, opcode}.
- Unused input fields are ignored.

States:
- IDLE: `in_ready`=1, `out_valid`=0.
  - Accepting a legal bundle (`in_valid`&&`in_ready`) latches the encoded word into the shift register and into `last_word`, sets idx=0, and goes to SEND.
  - Accepting `fmt`=3 stays in IDLE, pulses `err` next cycle, and changes no other state.
- SEND: `out_valid`=1; `out_byte` = byte idx in the configured order; `out_last` = (idx==3).
  - A byte transfer occurs on `out_valid`&&`out_ready`; it advances idx.
  - When idx==3 transfers, `insn_count` increments.
  - `in_ready` in SEND = (idx==3 && `out_ready`), so back-to-back accept is possible on the last byte.
  - If a legal bundle is accepted on the last byte: reload the word, idx=0, stay in SEND.
  - If an illegal bundle is accepted on the last byte: pulse `err` and go to IDLE.
  - If nothing is accepted on the last byte: go to IDLE.
- `out_byte`, `out_last` and idx hold while `out_ready`=0 (no drop, no duplicate).
- `out_valid` never deasserts before its byte transfers.

Reset (async, `rst_n`=0):
- state=IDLE, idx=0, `out_valid`=0, `out_byte`=0, `out_last`=0, `last_word`=0, `err`=0, `insn_count`=0.
- `in_ready` goes to 1 once reset is released.
- Reset mid-word discards the remaining bytes and does not count the word.

## Timing
- Accept at edge N → first byte valid after edge N, i.e. in cycle N+1. The fields must be sampled at edge N only.
- With `out_ready` held high, a word occupies 4 cycles. Sustained throughput is one word per 4 cycles with no bubble between words.
- `err` is registered: high for exactly one cycle after the accepting edge.
- `insn_count` and `last_word` are registered outputs:
  - `last_word` updates at the accept edge.
  - `insn_count` updates at the edge on which byte 3 transfers.
- `in_ready` is combinational from `out_ready` in SEND only. No other input-to-output combinational paths.

## Test plan
- U-format lui: `fmt`=2, `imm`=0x0AA01, `rd`=29, `opcode`=0x37 with `out_ready`=1.
  - Expect `last_word`=0x0AA01EB7.
  - Expect bytes B7,1E,A0,0A in cycles N+1..N+4, `out_last` only on 0A, and `insn_count`=1.
- R/I back-to-back: send R `add x3,x1,x2` (`func7`=0, `rs2`=2, `rs1`=1, `func3`=0, `rd`=3, `opcode`=0x33), then I `addi x5,x0,0x42` (`imm`=0x042, `rd`=5, `opcode`=0x13), presented continuously.
  - Expect 0x002081B3 then 0x04200293.
  - Expect 8 consecutive valid bytes with no gap and `insn_count`=2.
- Backpressure: U word from the first scenario with `out_ready` toggling 1,0,0,1,0,1,1.
  - Each byte must be held stable while stalled.
  - Order must remain B7,1E,A0,0A; no extra `out_valid` cycles.
- Illegal format: accept `fmt`=3 in IDLE.
  - Expect `err`=1 for exactly one cycle and no `out_valid`.
  - `insn_count` and `last_word` unchanged.
- MSB_FIRST=1 build with the lui word: expect bytes 0A,A0,1E,B7.
- Reset mid-word: assert `rst_n`=0 after byte 1 of 0x0AA01EB7 transfers.
  - Outputs go to reset values asynchronously and `insn_count`=0.
  - After release, the next word starts from byte 0.
- `insn_count` wrap: CNT_W=2 build, send 5 words; expect final `insn_count`=1.
